// File: rtl/serv_trap_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serv_trap_seq_pkg
// Purpose  : Shared state encodings, trap cause codes and CSR select/source
//            codes for the trap/CSR sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package serv_trap_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    localparam logic [3:0] c_cause_misalign_jmp = 4'd0;
    localparam logic [3:0] c_cause_ebreak       = 4'd3;
    localparam logic [3:0] c_cause_misalign_ld  = 4'd4;
    localparam logic [3:0] c_cause_misalign_st  = 4'd6;
    localparam logic [3:0] c_cause_timer        = 4'd7;
    localparam logic [3:0] c_cause_ecall        = 4'd11;

    localparam logic [2:0] c_csr_sel_mscratch = 3'd0;
    localparam logic [2:0] c_csr_sel_mtvec    = 3'd1;
    localparam logic [2:0] c_csr_sel_mepc     = 3'd2;
    localparam logic [2:0] c_csr_sel_mtval    = 3'd3;
    localparam logic [2:0] c_csr_sel_mcause   = 3'd4;
    localparam logic [2:0] c_csr_sel_mstatus  = 3'd5;

    localparam logic [1:0] c_csr_source_csr = 2'd0;
    localparam logic [1:0] c_csr_source_ext = 2'd1;
    localparam logic [1:0] c_csr_source_set = 2'd2;
    localparam logic [1:0] c_csr_source_clr = 2'd3;

    // Highest-priority cause wins; timer interrupt outranks all exceptions.
    function automatic logic [3:0] f_trap_cause(
        input logic timer,
        input logic ebreak,
        input logic ecall,
        input logic mis_jmp,
        input logic mis_ld,
        input logic mis_st
    );
        logic [3:0] cause;
        cause = c_cause_misalign_st;
        if (timer)        cause = c_cause_timer;
        else if (ebreak)  cause = c_cause_ebreak;
        else if (ecall)   cause = c_cause_ecall;
        else if (mis_jmp) cause = c_cause_misalign_jmp;
        else if (mis_ld)  cause = c_cause_misalign_ld;
        else if (mis_st)  cause = c_cause_misalign_st;
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_trap_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : serv_trap_seq_if
// Purpose  : Issue/exception/CSR signal bundle between decode and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface serv_trap_seq_if;
    logic       i_start;
    logic       i_csr_op;
    logic [2:0] i_csr_sel;
    logic [1:0] i_csr_source;
    logic       i_ecall;
    logic       i_ebreak;
    logic       i_misalign_jmp;
    logic       i_misalign_ld;
    logic       i_misalign_st;
    logic       i_mtip;
    logic       i_timer_irq_en;
    logic       i_pc;
    logic       i_addr;
    logic [4:0] o_cnt;
    logic       o_csr_en;
    logic       o_trap;
    logic [3:0] o_mcause;
    logic       o_mtval;
    logic [2:0] o_csr_sel;
    logic [1:0] o_csr_source;
    logic       o_busy;
    logic       o_done;
    logic       o_jmp_mtvec;

    modport master (
        output i_start, i_csr_op, i_csr_sel, i_csr_source,
        output i_ecall, i_ebreak, i_misalign_jmp, i_misalign_ld, i_misalign_st,
        output i_mtip, i_timer_irq_en, i_pc, i_addr,
        input  o_cnt, o_csr_en, o_trap, o_mcause, o_mtval,
        input  o_csr_sel, o_csr_source, o_busy, o_done, o_jmp_mtvec
    );

    modport slave (
        input  i_start, i_csr_op, i_csr_sel, i_csr_source,
        input  i_ecall, i_ebreak, i_misalign_jmp, i_misalign_ld, i_misalign_st,
        input  i_mtip, i_timer_irq_en, i_pc, i_addr,
        output o_cnt, o_csr_en, o_trap, o_mcause, o_mtval,
        output o_csr_sel, o_csr_source, o_busy, o_done, o_jmp_mtvec
    );
endinterface
`default_nettype wire

// File: rtl/serv_bitcnt.sv
`default_nettype none
// ============================================================================
// Module   : serv_bitcnt
// Purpose  : Free-wrapping serial bit counter with all-ones wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
module serv_bitcnt #(
    parameter int WIDTH = 5
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_cnt,
    output logic                  o_wrap
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = &r_cnt;
endmodule
`default_nettype wire

// File: rtl/serv_trap_seq.sv
`default_nettype none
// ============================================================================
// Module   : serv_trap_seq
// Purpose  : 32-cycle serial EXEC/TRAP sequencer with cause and mtval steering.
// Revision : 1.0 - initial release
// ============================================================================
module serv_trap_seq
    import serv_trap_seq_pkg::*;
(
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    serv_trap_seq_if.slave bus
);
    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_mcause;
    logic       r_csr_op;
    logic [2:0] r_csr_sel;
    logic [1:0] r_csr_source;
    logic       w_timer;
    logic       w_trap_cond;
    logic       w_accept;
    logic       w_wrap;
    logic       w_mtval;

    assign w_timer     = bus.i_mtip & bus.i_timer_irq_en;
    assign w_trap_cond = w_timer | bus.i_ecall | bus.i_ebreak |
                         bus.i_misalign_jmp | bus.i_misalign_ld | bus.i_misalign_st;
    // Issue is only honoured from IDLE; a start while busy changes nothing.
    assign w_accept    = (r_state == ST_IDLE) & bus.i_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_mcause     <= 4'd0;
            r_csr_op     <= 1'b0;
            r_csr_sel    <= 3'd0;
            r_csr_source <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_csr_op     <= bus.i_csr_op;
                r_csr_sel    <= bus.i_csr_sel;
                r_csr_source <= bus.i_csr_source;
                if (w_trap_cond)
                    r_mcause <= f_trap_cause(w_timer, bus.i_ebreak, bus.i_ecall,
                                             bus.i_misalign_jmp, bus.i_misalign_ld,
                                             bus.i_misalign_st);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.i_start) w_next = w_trap_cond ? ST_TRAP : ST_EXEC;
            ST_EXEC: if (w_wrap) w_next = ST_IDLE;
            ST_TRAP: if (w_wrap) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    serv_bitcnt #(.WIDTH(5)) u_bitcnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (r_state != ST_IDLE),
        .o_cnt  (bus.o_cnt),
        .o_wrap (w_wrap)
    );

    // mtval carries the faulting address for misalignment, the PC for ebreak.
    always_comb begin
        w_mtval = 1'b0;
        if (r_state == ST_TRAP) begin
            case (r_mcause)
                c_cause_misalign_jmp,
                c_cause_misalign_ld,
                c_cause_misalign_st: w_mtval = bus.i_addr;
                c_cause_ebreak:      w_mtval = bus.i_pc;
                default:             w_mtval = 1'b0;
            endcase
        end
    end

    assign bus.o_busy       = (r_state != ST_IDLE);
    assign bus.o_trap       = (r_state == ST_TRAP);
    assign bus.o_csr_en     = ((r_state == ST_EXEC) & r_csr_op) | (r_state == ST_TRAP);
    assign bus.o_csr_sel    = (r_state == ST_EXEC) ? r_csr_sel : 3'd0;
    assign bus.o_csr_source = (r_state == ST_EXEC) ? r_csr_source : 2'd0;
    assign bus.o_mcause     = r_mcause;
    assign bus.o_mtval      = w_mtval;
    assign bus.o_done       = (r_state != ST_IDLE) & w_wrap;
    assign bus.o_jmp_mtvec  = (r_state == ST_TRAP) & w_wrap;
endmodule
`default_nettype wire

// File: tb/tb_serv_trap_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_trap_seq
// Purpose  : Directed self-checking bench for the serial trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serv_trap_seq;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    serv_trap_seq_if bus ();

    serv_trap_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_start = 1'b0; bus.i_csr_op = 1'b0; bus.i_csr_sel = 3'd0;
        bus.i_csr_source = 2'd0; bus.i_ecall = 1'b0; bus.i_ebreak = 1'b0;
        bus.i_misalign_jmp = 1'b0; bus.i_misalign_ld = 1'b0; bus.i_misalign_st = 1'b0;
        bus.i_mtip = 1'b0; bus.i_timer_irq_en = 1'b0; bus.i_pc = 1'b0; bus.i_addr = 1'b0;
    endtask

    // flags = {mtip, irq_en, ecall, ebreak, mis_jmp, mis_ld, mis_st}
    task automatic issue(input logic csr_op, input logic [2:0] sel,
                         input logic [1:0] src, input logic [6:0] flags);
        bus.i_start = 1'b1; bus.i_csr_op = csr_op; bus.i_csr_sel = sel;
        bus.i_csr_source = src;
        {bus.i_mtip, bus.i_timer_irq_en, bus.i_ecall, bus.i_ebreak,
         bus.i_misalign_jmp, bus.i_misalign_ld, bus.i_misalign_st} = flags;
        tick();
        clear_inputs();
    endtask

    task automatic check_idle(input string tag, input logic [3:0] exp_mcause);
        check({tag, " busy"},   32'(bus.o_busy), 32'd0);
        check({tag, " cnt"},    32'(bus.o_cnt), 32'd0);
        check({tag, " trap"},   32'(bus.o_trap), 32'd0);
        check({tag, " done"},   32'(bus.o_done), 32'd0);
        check({tag, " jmp"},    32'(bus.o_jmp_mtvec), 32'd0);
        check({tag, " csr_en"}, 32'(bus.o_csr_en), 32'd0);
        check({tag, " mtval"},  32'(bus.o_mtval), 32'd0);
        check({tag, " sel"},    32'(bus.o_csr_sel), 32'd0);
        check({tag, " src"},    32'(bus.o_csr_source), 32'd0);
        check({tag, " mcause"}, 32'(bus.o_mcause), 32'(exp_mcause));
    endtask

    // Walk one 32-cycle phase; optionally inject an ignored start or a reset.
    task automatic run_phase(input string tag, input logic exp_trap, input logic exp_csr_en,
                             input logic [3:0] exp_mcause, input logic [2:0] exp_sel,
                             input logic [1:0] exp_src, input logic [31:0] pcw,
                             input logic [31:0] addrw, input logic [31:0] exp_mtval,
                             input int inject_at, input int rst_at);
        logic [31:0] mt;
        mt = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bus.i_pc   = pcw[i];
            bus.i_addr = addrw[i];
            if (i == inject_at) begin
                bus.i_start = 1'b1; bus.i_ecall = 1'b1; bus.i_csr_op = 1'b1;
                bus.i_csr_sel = 3'd7; bus.i_csr_source = 2'd3;
            end
            #1;
            check({tag, " cnt"},    32'(bus.o_cnt), 32'(i));
            check({tag, " busy"},   32'(bus.o_busy), 32'd1);
            check({tag, " trap"},   32'(bus.o_trap), 32'(exp_trap));
            check({tag, " csr_en"}, 32'(bus.o_csr_en), 32'(exp_csr_en));
            check({tag, " mcause"}, 32'(bus.o_mcause), 32'(exp_mcause));
            check({tag, " done"},   32'(bus.o_done), 32'(i == 31));
            check({tag, " jmp"},    32'(bus.o_jmp_mtvec), 32'((i == 31) && exp_trap));
            if (!exp_trap) begin
                check({tag, " sel"}, 32'(bus.o_csr_sel), 32'(exp_sel));
                check({tag, " src"}, 32'(bus.o_csr_source), 32'(exp_src));
            end
            mt[i] = bus.o_mtval;
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                clear_inputs();
                check_idle({tag, " abort"}, 4'd0);
                return;
            end
            tick();
            clear_inputs();
        end
        check({tag, " mtval word"}, mt, exp_mtval);
        check_idle({tag, " end"}, exp_mcause);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_idle("reset", 4'd0);
        rst = 1'b0;
        tick();
        check_idle("post reset", 4'd0);

        // Plain CSR instruction: EXEC with csr_en, latched select/source.
        issue(1'b1, 3'd5, 2'd2, 7'b0000000);
        run_phase("exec csr", 1'b0, 1'b1, 4'd0, 3'd5, 2'd2,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, -1, -1);

        // Non-CSR EXEC with a start+ecall at cnt 10 that must be ignored.
        issue(1'b0, 3'd1, 2'd1, 7'b0000000);
        run_phase("exec busy start", 1'b0, 1'b0, 4'd0, 3'd1, 2'd1,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 10, -1);
        tick();
        check_idle("after ignored start", 4'd0);

        issue(1'b0, 3'd0, 2'd0, 7'b0001000);
        run_phase("ebreak", 1'b1, 1'b1, 4'd3, 3'd0, 2'd0,
                  32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0104, -1, -1);

        issue(1'b0, 3'd0, 2'd0, 7'b1110000);
        run_phase("timer", 1'b1, 1'b1, 4'd7, 3'd0, 2'd0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, -1, -1);

        issue(1'b0, 3'd0, 2'd0, 7'b1010000);
        run_phase("ecall masked timer", 1'b1, 1'b1, 4'd11, 3'd0, 2'd0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, -1, -1);

        // Pending timer with interrupts disabled is not a trap.
        issue(1'b1, 3'd2, 2'd0, 7'b1000000);
        run_phase("mtip disabled", 1'b0, 1'b1, 4'd11, 3'd2, 2'd0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, -1, -1);

        issue(1'b0, 3'd0, 2'd0, 7'b0000010);
        run_phase("misalign ld", 1'b1, 1'b1, 4'd4, 3'd0, 2'd0,
                  32'hFFFF_FFFF, 32'h0000_1003, 32'h0000_1003, -1, -1);

        issue(1'b0, 3'd0, 2'd0, 7'b0000111);
        run_phase("multi misalign", 1'b1, 1'b1, 4'd0, 3'd0, 2'd0,
                  32'hFFFF_FFFF, 32'h8000_0002, 32'h8000_0002, -1, -1);
        tick();
        check_idle("single trap phase", 4'd0);

        issue(1'b0, 3'd0, 2'd0, 7'b0000001);
        run_phase("misalign st", 1'b1, 1'b1, 4'd6, 3'd0, 2'd0,
                  32'hFFFF_FFFF, 32'h0000_00A5, 32'h0000_00A5, -1, -1);

        issue(1'b0, 3'd0, 2'd0, 7'b0010000);
        run_phase("trap reset", 1'b1, 1'b1, 4'd11, 3'd0, 2'd0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, -1, 15);
        tick();
        check_idle("after trap reset", 4'd0);

        // Reset wins over a simultaneous trap-causing start.
        rst = 1'b1;
        issue(1'b1, 3'd4, 2'd1, 7'b0001000);
        rst = 1'b0;
        check_idle("reset vs start", 4'd0);
        tick();
        check_idle("reset vs start later", 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serv_trap_seq.md
SERV_TRAP_SEQ -- requirements
Module: serv_trap_seq

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: i_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: i_start  in  1  one-cycle instruction-issue pulse; i_csr_op  in  1  issued instruction is a CSR access.
REQ-004 SHALL have: i_csr_sel  in  3  and  i_csr_source  in  2  decoded CSR select/source, valid with i_start.
REQ-005 SHALL have: i_ecall, i_ebreak, i_misalign_jmp, i_misalign_ld, i_misalign_st  in  1 each  exception flags, valid with i_start.
REQ-006 SHALL have: i_mtip  in  1  timer pending; i_timer_irq_en  in  1  mstatus.MIE & mie.MTIE from CSR block.
REQ-007 SHALL have: i_pc, i_addr  in  1 each  serial PC / faulting-address bits, LSB first, aligned to o_cnt.
REQ-008 SHALL have: o_cnt  out  5  bit index; o_csr_en  out  1  CSR block enable; o_trap  out  1  trap phase; o_mcause  out  4  cause code; o_mtval  out  1  serial mtval bit.
REQ-009 SHALL have: o_csr_sel  out  3; o_csr_source  out  2; o_busy  out  1; o_done  out  1  last-cycle pulse; o_jmp_mtvec  out  1  redirect PC to mtvec.

Function
REQ-010 SHALL implement states IDLE, EXEC, TRAP; o_busy = (state != IDLE).
REQ-011 In IDLE, i_start SHALL move to TRAP if any trap condition (REQ-013) holds, else to EXEC, on the next edge, with o_cnt = 0.
REQ-012 o_cnt SHALL increment by 1 each cycle in EXEC/TRAP; at o_cnt = 31 state SHALL return to IDLE and o_cnt wrap to 0.
REQ-013 Trap condition = (i_mtip & i_timer_irq_en) | i_ecall | i_ebreak | any misalign flag, sampled only at i_start.
REQ-014 Cause priority, latched into o_mcause at i_start: timer 7 > ebreak 3 > ecall 11 > misalign_jmp 0 > misalign_ld 4 > misalign_st 6.
REQ-015 o_mcause SHALL hold its value until the next trap-causing i_start.
REQ-016 i_csr_sel, i_csr_source, i_csr_op SHALL be latched at i_start and driven on o_csr_sel/o_csr_source throughout EXEC.
REQ-017 o_csr_en SHALL be (EXEC & latched csr_op) | TRAP.
REQ-018 o_trap SHALL be 1 for exactly the 32 TRAP cycles.
REQ-019 o_mtval SHALL be i_addr in TRAP for misalign causes, i_pc for ebreak, else 0; 0 outside TRAP.
REQ-020 o_done SHALL be 1 in the cycle with o_cnt = 31 in EXEC or TRAP; o_jmp_mtvec SHALL be 1 in that cycle only if TRAP.
REQ-021 i_start while o_busy SHALL be ignored; no state, latch or counter change.
REQ-022 i_start with i_mtip high but i_timer_irq_en low SHALL go to EXEC.
REQ-023 Simultaneous multiple exception flags SHALL record only the highest-priority cause; a single TRAP phase is run.

Reset
REQ-024 i_rst SHALL force state IDLE, o_cnt 0, o_mcause 0, latched csr_op 0, taking priority over i_start in the same cycle.
REQ-025 After reset all outputs SHALL be 0: o_trap, o_csr_en, o_busy, o_done, o_jmp_mtvec, o_mtval, o_csr_sel, o_csr_source.
REQ-026 Reset mid-EXEC/TRAP SHALL abort the phase without o_done or o_jmp_mtvec.

Structure
REQ-027 State encodings, cause codes (0,3,4,6,7,11) and CSR_SEL_*/CSR_SOURCE_* SHALL live in the shared serv_params header.
REQ-028 The 5-bit counter with wrap flag SHALL be one sub-module, serv_bitcnt; all else inline.

Verification
REQ-029 Reset, then i_start, csr_op=1, no flags -> 32 EXEC cycles, o_cnt 0..31, o_csr_en=1, o_done at cnt 31, o_trap=0.
REQ-030 i_start with i_ebreak=1, i_pc stream 0x00000104 -> o_mcause=3, o_trap 32 cycles, o_mtval serializes 0x00000104, o_jmp_mtvec at cnt 31.
REQ-031 i_start with i_mtip=1, i_timer_irq_en=1, i_ecall=1 -> o_mcause=7, o_mtval all 0; same with i_timer_irq_en=0 -> o_mcause=11.
REQ-032 i_start with i_misalign_ld=1, i_addr 0x00001003 -> o_mcause=4, o_mtval serializes 0x00001003.
REQ-033 i_start at cnt 10 of EXEC -> ignored, o_done at cnt 31 once; i_rst at TRAP cnt 15 -> IDLE next cycle, no o_jmp_mtvec.
